button_counter: RTL and testbench

//  Parametrised successor of the single-button counter for board test projects.

---
 rtl/button_counter.sv | 146 ++++++++++++++
 tb/tb_button_counter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_counter.sv
// Debounced push-button counter: per-button synchroniser, debouncer and press detector
// feeding a modulo-(MAX_COUNT+1) counter. Define BUTTON_COUNTER_DOWN_EN to add a down button.

module button_counter_path #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   db_q, db_d;
  logic                   db_prev_q, db_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   s;

  // Accept a new level only after an unbroken run of disagreeing samples.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], btn_in};
    s         = sync_q[SYNC_STAGES-1];
    db_d      = db_q;
    cnt_d     = cnt_q;
    db_prev_d = db_q;
    if (s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign press = db_q & ~db_prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= sync_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

module button_counter #(
  parameter int             WIDTH           = 8,
  parameter longint unsigned MAX_COUNT      = (64'd1 << WIDTH) - 64'd1,
  parameter int             SYNC_STAGES     = 2,
  parameter int             DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
`ifdef BUTTON_COUNTER_DOWN_EN
  input  logic             btn_dn,
`endif
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             pressed,
  output logic             wrapped
);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_COUNT[WIDTH-1:0];

  logic             press_up;
  logic             press_dn;
  logic [WIDTH-1:0] out_q, out_d;
  logic             pressed_q, pressed_d;
  logic             wrapped_q, wrapped_d;

  button_counter_path #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_up_path (
    .clk   (clk),
    .rst   (rst),
    .btn_in(btn_in),
    .press (press_up)
  );

`ifdef BUTTON_COUNTER_DOWN_EN
  button_counter_path #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dn_path (
    .clk   (clk),
    .rst   (rst),
    .btn_in(btn_dn),
    .press (press_dn)
  );
`else
  assign press_dn = 1'b0;
`endif

  // Clear wins over any press; opposing presses on one edge cancel out.
  always_comb begin
    out_d     = out_q;
    pressed_d = press_up | press_dn;
    wrapped_d = 1'b0;
    if (clr) begin
      out_d = '0;
    end else if (press_up && press_dn) begin
      out_d = out_q;
    end else if (press_up) begin
      if (out_q == MAX_VAL) begin
        out_d     = '0;
        wrapped_d = 1'b1;
      end else begin
        out_d = out_q + WIDTH'(1);
      end
    end else if (press_dn) begin
      if (out_q == '0) begin
        out_d     = MAX_VAL;
        wrapped_d = 1'b1;
      end else begin
        out_d = out_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q     <= '0;
      pressed_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      pressed_q <= pressed_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign out     = out_q;
  assign pressed = pressed_q;
  assign wrapped = wrapped_q;
endmodule

// File: tb/tb_button_counter.sv
// Self-checking bench for button_counter: directed scenarios plus randomized bouncy
// button traffic, all checked against a sample-window reference model.

module tb_button_counter;
   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int MAXC = 9;
`ifdef BUTTON_COUNTER_DOWN_EN
   localparam bit DOWN = 1'b1;
`else
   localparam bit DOWN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       btn_in;
   logic       btn_dn;
   logic       clr;
   logic [3:0] out;
   logic       pressed;
   logic       wrapped;

   int compareCount = 0;
   int failCount    = 0;

   button_counter #(
      .WIDTH          (4),
      .MAX_COUNT      (MAXC),
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_in),
`ifdef BUTTON_COUNTER_DOWN_EN
      .btn_dn (btn_dn),
`endif
      .clr    (clr),
      .out    (out),
      .pressed(pressed),
      .wrapped(wrapped)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
      end
   endtask

   // Reference model history: one entry per clock edge, recording what was sampled.
   bit rstQ[$];
   bit upQ[$];
   bit dnQ[$];
   int mDb[2];
   int mLast[2];
   int mRise[2];
   int mOut;
   bit mPressed;
   bit mWrapped;
   bit started = 1'b0;

   // Level seen by the debouncer at edge j: the raw sample SYNC edges earlier,
   // or zero if a reset flushed the synchroniser in between.
   function automatic bit sUsed(input int b, input int j);
      if (j - SYNC < 0) return 1'b0;
      for (int k = 1; k < SYNC; k++) begin
         if (rstQ[j-k]) return 1'b0;
      end
      return (b == 1) ? dnQ[j-SYNC] : upQ[j-SYNC];
   endfunction

   // Model: a button level is accepted once the last DEB debouncer samples since the
   // previous reset/acceptance all disagree with it; a press is registered one edge later.
   always @(posedge clk) begin : refModel
      int  n;
      bit  pu;
      bit  pd;
      bit  ok;
      started = 1'b1;
      rstQ.push_back(!rst);
      upQ.push_back(rst ? btn_in : 1'b0);
      dnQ.push_back((rst && DOWN) ? btn_dn : 1'b0);
      n = rstQ.size() - 1;
      if (!rst) begin
         for (int b = 0; b < 2; b++) begin
            mDb[b]   = 0;
            mLast[b] = n;
            mRise[b] = -100;
         end
         mOut     = 0;
         mPressed = 1'b0;
         mWrapped = 1'b0;
      end else begin
         pu = (mRise[0] == n - 1);
         pd = DOWN && (mRise[1] == n - 1);
         for (int b = 0; b < 2; b++) begin
            if (n - DEB + 1 > mLast[b]) begin
               ok = 1'b1;
               for (int j = n - DEB + 1; j <= n; j++) begin
                  if (int'(sUsed(b, j)) == mDb[b]) ok = 1'b0;
               end
               if (ok) begin
                  mDb[b]   = 1 - mDb[b];
                  mLast[b] = n;
                  if (mDb[b] == 1) mRise[b] = n;
               end
            end
         end
         mPressed = pu | pd;
         mWrapped = 1'b0;
         if (clr) begin
            mOut = 0;
         end else if (pu && pd) begin
            mOut = mOut;
         end else if (pu) begin
            if (mOut == MAXC) begin
               mOut     = 0;
               mWrapped = 1'b1;
            end else begin
               mOut = mOut + 1;
            end
         end else if (pd) begin
            if (mOut == 0) begin
               mOut     = MAXC;
               mWrapped = 1'b1;
            end else begin
               mOut = mOut - 1;
            end
         end
      end
   end

   // Every cycle, compare the DUT outputs with the model half a period after the edge.
   always @(negedge clk) begin
      if (started) begin
         checkOutput("model_out", 32'(out), 32'(mOut));
         checkOutput("model_pressed", 32'(pressed), 32'(mPressed));
         checkOutput("model_wrapped", 32'(wrapped), 32'(mWrapped));
      end
   end

   // Advance n clock edges, leaving time just after the last edge for new drives.
   task automatic waitEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive both buttons and clear, then hold them for the given number of edges.
   task automatic applyStimulus(input logic up, input logic dn, input logic c, input int cycles);
      btn_in = up;
      btn_dn = dn;
      clr    = c;
      waitEdges(cycles);
   endtask

   task automatic doReset();
      rst = 1'b0;
      waitEdges(3);
      rst = 1'b1;
   endtask

   // Clean press: check the counter at the expected latency, then release fully.
   task automatic pressOnce(input logic up, input logic dn, input int expOut, input bit expWrap);
      applyStimulus(up, dn, 1'b0, 7);
      @(negedge clk);
      checkOutput("press_out", 32'(out), 32'(expOut));
      checkOutput("press_pulse", 32'(pressed), 32'd1);
      checkOutput("press_wrap", 32'(wrapped), 32'(expWrap));
      waitEdges(2);
      applyStimulus(1'b0, 1'b0, 1'b0, 9);
   endtask

   initial begin
      rst    = 1'b0;
      btn_in = 1'b0;
      btn_dn = 1'b0;
      clr    = 1'b0;
      doReset();

      // Reset state, then one held press with exact latency and a single pulse.
      @(negedge clk);
      checkOutput("reset_out", 32'(out), 32'd0);
      checkOutput("reset_pressed", 32'(pressed), 32'd0);
      checkOutput("reset_wrapped", 32'(wrapped), 32'd0);
      btn_in = 1'b1;
      waitEdges(6);
      @(negedge clk);
      checkOutput("lat_before", 32'(out), 32'd0);
      waitEdges(1);
      @(negedge clk);
      checkOutput("lat_out", 32'(out), 32'd1);
      checkOutput("lat_pressed", 32'(pressed), 32'd1);
      waitEdges(1);
      @(negedge clk);
      checkOutput("lat_pulse_end", 32'(pressed), 32'd0);
      waitEdges(12);
      checkOutput("held_out", 32'(out), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 10);
      checkOutput("release_out", 32'(out), 32'd1);

      // Bouncing input settles into exactly one press; isolated glitches are ignored.
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus((i % 2) == 0, 1'b0, 1'b0, 2);
      applyStimulus(1'b1, 1'b0, 1'b0, 12);
      checkOutput("bounce_out", 32'(out), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 10);
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1);
         applyStimulus(1'b0, 1'b0, 1'b0, 5);
      end
      checkOutput("glitch_out", 32'(out), 32'd0);

      // Ten presses walk 1..9 and wrap to 0 with a wrap pulse only on the last.
      doReset();
      for (int p = 1; p <= 10; p++) pressOnce(1'b1, 1'b0, p % 10, p == 10);

      // Clear held across a press edge at out=5.
      doReset();
      for (int p = 1; p <= 5; p++) pressOnce(1'b1, 1'b0, p, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 5);
      applyStimulus(1'b1, 1'b0, 1'b1, 2);
      @(negedge clk);
      checkOutput("clr_out", 32'(out), 32'd0);
      checkOutput("clr_pressed", 32'(pressed), 32'd1);
      checkOutput("clr_wrapped", 32'(wrapped), 32'd0);
      waitEdges(2);
      applyStimulus(1'b0, 1'b0, 1'b0, 9);

      // Reset mid-debounce with the button held: progress discarded, one press afterwards.
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 5);
      rst = 1'b0;
      waitEdges(1);
      @(negedge clk);
      checkOutput("midrst_pressed0", 32'(pressed), 32'd0);
      waitEdges(1);
      @(negedge clk);
      checkOutput("midrst_pressed1", 32'(pressed), 32'd0);
      checkOutput("midrst_out", 32'(out), 32'd0);
      rst = 1'b1;
      waitEdges(6);
      @(negedge clk);
      checkOutput("midrst_before", 32'(out), 32'd0);
      waitEdges(1);
      @(negedge clk);
      checkOutput("midrst_after", 32'(out), 32'd1);
      checkOutput("midrst_pulse", 32'(pressed), 32'd1);
      waitEdges(2);
      applyStimulus(1'b0, 1'b0, 1'b0, 9);

`ifdef BUTTON_COUNTER_DOWN_EN
      // Down press wraps 0 -> MAX; simultaneous up+down holds the count.
      doReset();
      pressOnce(1'b0, 1'b1, MAXC, 1'b1);
      pressOnce(1'b1, 1'b0, 0, 1'b1);
      for (int p = 1; p <= 3; p++) pressOnce(1'b1, 1'b0, p, 1'b0);
      pressOnce(1'b1, 1'b1, 3, 1'b0);
`endif

      // Randomized bouncy traffic with occasional clears and resets.
      doReset();
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 99) < 3) begin
            rst = 1'b0;
            waitEdges($urandom_range(1, 3));
            rst = 1'b1;
         end else begin
            repeat ($urandom_range(0, 4)) begin
               applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                             $urandom_range(1, 3));
            end
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 19) == 0, $urandom_range(1, 12));
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end
endmodule
